// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory stage of a five-stage pipeline with a wait-state
// data memory.
//
// Loads and stores take WAIT_CYCLES+1 cycles from presentation to MEM/WB
// capture. While an access is in flight, stall holds the upstream pipeline
// and bubbles are loaded into MEM/WB. Non-memory ops pass straight through
// with one-cycle latency.
//
// Parameters
//   ADDR_W       log2 of data-memory depth in 32-bit words
//   WAIT_CYCLES  extra clock cycles per load/store (0..15)
//
// Ports
//   clock, reset            clock; asynchronous active-high reset
//   mwreg, mm2reg, mwmem    EXE/MEM register-write, load, store controls
//   mdestReg                EXE/MEM destination register number
//   mr                      ALU result, used as the byte address
//   mqb                     store data
//   stall                   combinational hold request to upstream stages
//   wwreg, wm2reg           MEM/WB controls
//   wdestReg, wr, wdo       MEM/WB destination, ALU result, load data
//   misalign                (only with MEM_MISALIGN_CHECK_EN) registered flag
//                           for a memory op with mr[1:0] != 0
//
// Build option
//   MEM_MISALIGN_CHECK_EN   adds the misalign output and suppresses
//                           misaligned stores
// -----------------------------------------------------------------------------
module mem_stage #(
   parameter int ADDR_W      = 6,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mwreg,
   input  logic        mm2reg,
   input  logic        mwmem,
   input  logic [4:0]  mdestReg,
   input  logic [31:0] mr,
   input  logic [31:0] mqb,
   output logic        stall,
   output logic        wwreg,
   output logic        wm2reg,
   output logic [4:0]  wdestReg,
   output logic [31:0] wr,
`ifdef MEM_MISALIGN_CHECK_EN
   output logic [31:0] wdo,
   output logic        misalign
`else
   output logic [31:0] wdo
`endif
);

   localparam int         DEPTH  = 1 << ADDR_W;
   localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        stall_int;
   logic        capture;
   logic        mem_op;
   logic        misalign_hit;
   logic        mem_we;
   logic [ADDR_W-1:0] word_addr;
   logic [31:0] rd_data;

   logic        wwreg_q, wm2reg_q;
   logic [4:0]  wdestReg_q;
   logic [31:0] wr_q, wdo_q;

   // NOTE: memory arrays are never reset; contents come from the declaration
   // initialiser at time zero and survive reset pulses.
   logic [31:0] mem_q [DEPTH] = '{default: 32'd0};

   assign mem_op    = mm2reg | mwmem;
   assign word_addr = mr[ADDR_W+1:2];
   assign rd_data   = mem_q[word_addr];

`ifdef MEM_MISALIGN_CHECK_EN
   assign misalign_hit = (mr[1:0] != 2'b00);
`else
   assign misalign_hit = 1'b0;
   // Byte-offset bits play no part in the access in this build.
   logic unused_byte_offset;
   assign unused_byte_offset = ^mr[1:0];
`endif

   // High-order address bits alias onto the same words by design.
   logic unused_high_addr;
   assign unused_high_addr = ^mr[31:ADDR_W+2];

   // Next-state logic. capture marks the edge that loads a real instruction
   // into MEM/WB; every other edge loads a bubble.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_int = 1'b0;
      capture   = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_op && (WAIT_N != 4'd0)) begin
               stall_int = 1'b1;
               state_d   = BUSY;
               cnt_d     = WAIT_N;
            end else begin
               capture = 1'b1;
            end
         end
         BUSY: begin
            if (cnt_q > 4'd1) begin
               stall_int = 1'b1;
               cnt_d     = cnt_q - 4'd1;
            end else begin
               // Final wait cycle: upstream is released and the access
               // completes on the coming edge.
               capture = 1'b1;
               state_d = IDLE;
               cnt_d   = 4'd0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   assign stall = stall_int & ~reset;

   // Gating with reset keeps an in-flight store from landing while reset is
   // held across an edge.
   assign mem_we = capture & mwmem & ~misalign_hit & ~reset;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; a load paired with a store therefore reads the
   // old word.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem_q[word_addr] <= mqb;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         wwreg_q    <= 1'b0;
         wm2reg_q   <= 1'b0;
         wdestReg_q <= 5'd0;
         wr_q       <= 32'd0;
         wdo_q      <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (capture) begin
            wwreg_q    <= mwreg;
            wm2reg_q   <= mm2reg;
            wdestReg_q <= mdestReg;
            wr_q       <= mr;
            wdo_q      <= mm2reg ? rd_data : 32'd0;
         end else begin
            // Bubble: kill the write-back controls, keep the data fields.
            wwreg_q  <= 1'b0;
            wm2reg_q <= 1'b0;
         end
      end
   end

`ifdef MEM_MISALIGN_CHECK_EN
   logic misalign_q;

   // The flag follows captures only; bubbles leave it unchanged.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         misalign_q <= 1'b0;
      end else if (capture) begin
         misalign_q <= mem_op & misalign_hit;
      end
   end

   assign misalign = misalign_q;
`endif

   assign wwreg    = wwreg_q;
   assign wm2reg   = wm2reg_q;
   assign wdestReg = wdestReg_q;
   assign wr       = wr_q;
   assign wdo      = wdo_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning log2 of data-memory depth in 32-bit words (64 words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning extra clock cycles per load/store (0..15).
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have inputs mwreg, mm2reg, mwmem, each 1 bit: register-write, load and store controls from the EXE/MEM register.
REQ-006 SHALL have input mdestReg, 5 bits: destination register number.
REQ-007 SHALL have input mr, 32 bits: ALU result, used as the byte address.
REQ-008 SHALL have input mqb, 32 bits: store data.
REQ-009 SHALL have output stall, 1 bit: combinational; upstream holds the EXE/MEM register and earlier stages while it is high.
REQ-010 SHALL have registered outputs wwreg and wm2reg, each 1 bit: MEM/WB controls.
REQ-011 SHALL have registered output wdestReg, 5 bits: MEM/WB destination.
REQ-012 SHALL have registered outputs wr and wdo, each 32 bits: MEM/WB ALU result and load data.

Function
REQ-013 SHALL contain a 2^ADDR_W x 32 data memory indexed by mr[ADDR_W+1:2]; address bits above ADDR_W+1 are ignored.
REQ-014 SHALL classify a cycle as a memory op when mm2reg or mwmem is 1.
REQ-015 SHALL use FSM states IDLE and BUSY, with a 4-bit down-counter cnt.
REQ-016 IDLE, non-memory op: stall=0; the next edge latches wwreg, wm2reg, wdestReg, wr and wdo=0 into MEM/WB, giving 1-cycle latency.
REQ-017 IDLE, memory op, WAIT_CYCLES=0: stall=0; the access completes on the next edge.
REQ-018 IDLE, memory op, WAIT_CYCLES>0: stall=1; the next edge moves to BUSY with cnt=WAIT_CYCLES and loads a bubble into MEM/WB.
REQ-019 BUSY with cnt>1: stall=1; each edge decrements cnt and loads a bubble.
REQ-020 BUSY with cnt=1: stall=0; the next edge completes the access and returns to IDLE.
REQ-021 A memory op SHALL take exactly WAIT_CYCLES+1 cycles from presentation to MEM/WB capture.
REQ-022 On the completion edge, a store (mwmem=1) SHALL write mqb to the memory; no write SHALL occur on any other edge.
REQ-023 On the completion edge, a load (mm2reg=1) SHALL capture the memory word into wdo.
REQ-024 If mwmem and mm2reg are both 1, the load SHALL return the old contents and the store SHALL update the memory after it.
REQ-025 A bubble SHALL set wwreg=0 and wm2reg=0, leave wdestReg, wr and wdo at their previous values, and not write memory.
REQ-026 While stall=1, inputs SHALL be held stable by upstream; the block is not required to handle inputs that change mid-op.
REQ-027 A load and a following store to the same word SHALL behave in program order.

Reset
REQ-028 Reset SHALL immediately force state=IDLE, cnt=0, and wwreg, wm2reg, wdestReg, wr and wdo all to 0.
REQ-029 stall SHALL read 0 while reset is high.
REQ-030 Reset asserted during BUSY SHALL abort the access with no memory write.
REQ-031 Memory contents SHALL not be altered by reset and SHALL be initialised to 0 at time zero.

Configuration
REQ-032 With macro MEM_MISALIGN_CHECK_EN defined, the block SHALL add a registered output misalign, 1 bit, reset to 0.
REQ-033 With MEM_MISALIGN_CHECK_EN defined, misalign SHALL be set on the completion edge when mr[1:0]!=0 for a memory op, and cleared on all other captures.
REQ-034 With MEM_MISALIGN_CHECK_EN defined, a misaligned store SHALL be suppressed.
REQ-035 Without MEM_MISALIGN_CHECK_EN, the misalign port SHALL not exist and mr[1:0] SHALL be ignored.

Verification
REQ-036 Bench SHALL cover: ALU op mwreg=1, mdestReg=5, mr=0x2A -> next cycle wwreg=1, wdestReg=5, wr=0x2A, wdo=0, stall never high.
REQ-037 Bench SHALL cover: WAIT_CYCLES=1, store mr=0x8, mqb=0xDEADBEEF, then load mr=0x8 -> stall high 1 cycle per op; wdo=0xDEADBEEF two cycles after load presented.
REQ-038 Bench SHALL cover: WAIT_CYCLES=3, load -> stall high for exactly 3 cycles, 3 bubbles (wwreg=0), capture on 4th edge.
REQ-039 Bench SHALL cover: reset pulsed in BUSY during a store of 0x1234 to mr=0x10 -> outputs 0, FSM IDLE, later load of 0x10 returns prior value 0.
REQ-040 Bench SHALL cover: WAIT_CYCLES=0, back-to-back store/load same address -> stall never high, load returns stored data.
REQ-041 Bench SHALL cover: with MEM_MISALIGN_CHECK_EN, store mr=0x6 -> misalign=1, word at 0x4 unchanged.
